// File: rtl/alu_pkg.sv
// Shared ALU encodings: issuer FSM states, unit selects, CMP op and result codes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issuer_state_t;

    // Upper two bits of the function code pick the unit
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] CMP_NOP = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_LT  = 2'b11;

    localparam logic [1:0] CMP_RES_NONE = 2'd0;
    localparam logic [1:0] CMP_RES_EQ   = 2'd1;
    localparam logic [1:0] CMP_RES_GT   = 2'd2;
    localparam logic [1:0] CMP_RES_LT   = 2'd3;

endpackage

// File: rtl/issuer_timeout_cnt.sv
// Clearable saturating cycle counter; tc flags the last allowed WAIT cycle.
module issuer_timeout_cnt #(
    parameter int TIMEOUT = 8,
    parameter int W       = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Single-outstanding command issuer for the registered ALU units, with a
// WAIT timeout so a silent unit still yields an (error) result.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FUN_W   = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [FUN_W-1:0] cmd_fun,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    issuer_state_t state_q, state_d;
    logic          to_tc;

    issuer_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .W       (8)
    ) u_to (
        .CLK (CLK),
        .RST (RST),
        .clr (state_q == ISSUE),
        .inc ((state_q == WAIT) && !alu_valid),
        .tc  (to_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_valid || to_tc) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        alu_en    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE:    cmd_ready = 1'b1;
            ISSUE:   alu_en    = 1'b1;
            HOLD:    res_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands stay put from acceptance to the next accept so the unit sees stable inputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fun  <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            op_count <= '0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_fun <= cmd_fun;
            end
            // A flag on the terminal-count cycle still counts as a real answer
            if (state_q == WAIT) begin
                if (alu_valid) begin
                    res_data <= alu_out;
                    res_err  <= 1'b0;
                end else if (to_tc) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                end
            end
            if (state_q == HOLD && res_ready)
                op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer against a registered CMP unit model.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_fun;
    logic [15:0] cmd_a, cmd_b;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic [7:0]  op_count;

    // 0: registered CMP unit, 1: silent unit, 2: flag/data from man_* variables
    int          model_mode = 0;
    logic        man_valid  = 1'b0;
    logic [15:0] man_out    = '0;
    logic        prev_en    = 1'b0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    alu_cmd_issuer #(.WIDTH(16), .FUN_W(4), .TIMEOUT(8), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_fun   (cmd_fun),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_en    (alu_en),
        .alu_out   (alu_out),
        .alu_valid (alu_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .op_count  (op_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] cmp_model(input logic [3:0] f, input logic [15:0] a,
                                              input logic [15:0] b);
        if (f[3:2] != UNIT_CMP) return 16'd0;
        case (f[1:0])
            CMP_EQ:  return (a == b) ? 16'(CMP_RES_EQ) : 16'd0;
            CMP_GT:  return (a > b)  ? 16'(CMP_RES_GT) : 16'd0;
            CMP_LT:  return (a < b)  ? 16'(CMP_RES_LT) : 16'd0;
            default: return 16'(CMP_RES_NONE);
        endcase
    endfunction

    // Unit model: answers on the cycle after alu_en, updated away from the rising edge
    always @(negedge CLK) begin
        if (model_mode == 2) begin
            alu_valid = man_valid;
            alu_out   = man_out;
        end else begin
            alu_valid = (model_mode == 0) && prev_en;
            alu_out   = prev_en ? cmp_model(alu_fun, alu_a, alu_b) : 16'd0;
        end
        prev_en = alu_en;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_fun = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b0; alu_valid = 1'b0; alu_out = '0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_en",    alu_en,    0);
        check("rst_res_valid", res_valid, 0);
        check("rst_op_count",  op_count,  0);
        tick; tick;
        RST = 1'b0;

        // CMP EQ 5==5
        model_mode = 0; res_ready = 1'b1;
        issue(4'b1001, 16'd5, 16'd5);
        check("t1_en_issue",   alu_en,    1);
        check("t1_ready_low",  cmd_ready, 0);
        check("t1_alu_fun",    alu_fun,   4'b1001);
        tick;
        check("t1_en_drop",    alu_en,    0);
        check("t1_no_res_yet", res_valid, 0);
        tick;
        check("t1_res_valid",  res_valid, 1);
        check("t1_res_data",   res_data,  1);
        check("t1_res_err",    res_err,   0);
        tick;
        check("t1_back_idle",  res_valid, 0);
        check("t1_op_count",   op_count,  1);

        // GT then LT back to back, cmd_valid held
        cmd_fun = 4'b1010; cmd_a = 16'd9; cmd_b = 16'd3; cmd_valid = 1'b1;
        tick;
        cmd_fun = 4'b1011;
        tick;
        check("t2_ready_wait", cmd_ready, 0);
        tick;
        check("t2_gt_data",    res_data,  2);
        check("t2_ready_hold", cmd_ready, 0);
        tick;
        check("t2_ready_idle", cmd_ready, 1);
        check("t2_op_count1",  op_count,  2);
        check("t2_fun_kept",   alu_fun,   4'b1010);
        tick;
        cmd_valid = 1'b0;
        check("t2_fun_lt",     alu_fun,   4'b1011);
        tick; tick;
        check("t2_lt_valid",   res_valid, 1);
        check("t2_lt_data",    res_data,  0);
        tick;
        check("t2_op_count2",  op_count,  3);

        // Result held while consumer stalls
        res_ready = 1'b0;
        issue(4'b1001, 16'd7, 16'd7);
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_data",  res_data,  1);
            check("t3_hold_ready", cmd_ready, 0);
            tick;
        end
        check("t3_no_count",   op_count,  3);
        res_ready = 1'b1;
        tick;
        check("t3_released",   res_valid, 0);
        check("t3_op_count",   op_count,  4);

        // Silent unit: timeout after TIMEOUT WAIT cycles
        model_mode = 1;
        issue(4'b0000, 16'd1, 16'd1);
        tick;
        repeat (7) tick;
        check("t4_pre_tc",     res_valid, 0);
        tick;
        check("t4_to_valid",   res_valid, 1);
        check("t4_to_err",     res_err,   1);
        check("t4_to_data",    res_data,  0);
        tick;
        check("t4_op_count",   op_count,  5);

        // Flag in IDLE must not capture
        model_mode = 2; man_valid = 1'b1; man_out = 16'hBEEF;
        tick; tick;
        check("t5_idle_valid", res_valid, 0);
        check("t5_idle_data",  res_data,  0);
        check("t5_idle_ready", cmd_ready, 1);
        man_valid = 1'b0; man_out = '0;
        tick;

        // Flag on terminal-count cycle wins over timeout
        issue(4'b1001, 16'd3, 16'd3);
        tick;
        repeat (7) tick;
        check("t5_pre_tc",     res_valid, 0);
        man_valid = 1'b1; man_out = 16'h1234;
        tick;
        man_valid = 1'b0; man_out = '0;
        check("t5_tc_valid",   res_valid, 1);
        check("t5_tc_err",     res_err,   0);
        check("t5_tc_data",    res_data,  16'h1234);
        tick;
        check("t5_op_count",   op_count,  6);

        // Reset in WAIT discards the operation
        model_mode = 1;
        issue(4'b1001, 16'h00AB, 16'h00CD);
        tick;
        check("t6_alu_a_pre",  alu_a,     16'h00AB);
        RST = 1'b1;
        #1;
        check("t6_rst_ready",  cmd_ready, 1);
        check("t6_rst_en",     alu_en,    0);
        check("t6_rst_valid",  res_valid, 0);
        check("t6_rst_err",    res_err,   0);
        check("t6_rst_data",   res_data,  0);
        check("t6_rst_alu_a",  alu_a,     0);
        check("t6_rst_alu_b",  alu_b,     0);
        check("t6_rst_fun",    alu_fun,   0);
        check("t6_rst_count",  op_count,  0);
        tick;
        RST = 1'b0;
        model_mode = 0;
        issue(4'b1001, 16'd1, 16'd2);
        tick; tick;
        check("t6_post_valid", res_valid, 1);
        check("t6_post_data",  res_data,  0);
        check("t6_post_err",   res_err,   0);
        tick;
        check("t6_post_count", op_count,  1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
